fir_fixed_mac_pipe: RTL and testbench



---
 rtl/fir_fixed_pkg.sv | 53 +++++
 rtl/fir_fixed_mul_core.sv | 84 ++++++++
 rtl/fir_fixed_mac_pipe.sv | 102 ++++++++++
 tb/tb_fir_fixed_mac_pipe.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_fixed_pkg.sv
// Shared widths and the round/saturate helper for the fixed-point FIR datapath.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package fir_fixed_pkg;

  // Default datapath widths.
  localparam int FIR_A_W        = 24;
  localparam int FIR_B_W        = 18;
  localparam int FIR_ACC_W      = 48;
  localparam int FIR_OUT_W      = 24;
  localparam int FIR_FRAC_SHIFT = 17;

  // Working width for sat_round. Any accumulator up to SAT_W-2 bits is
  // sign-extended into it, so adding the rounding term can never overflow.
  localparam int SAT_W = 128;

  localparam logic signed [SAT_W-1:0] SAT_ONE = {{(SAT_W-1){1'b0}}, 1'b1};

  typedef struct packed {
    logic signed [SAT_W-1:0] value;  // rounded, clipped result (sign-extended)
    logic                    sat;    // 1 when the result was clipped
  } sat_round_t;

  // Round half up at bit 'shift', arithmetic shift right, then clip into a
  // signed out_w-bit range. shift=0 adds no rounding term.
  function automatic sat_round_t sat_round(input logic signed [SAT_W-1:0] acc,
                                           input int shift,
                                           input int out_w);
    logic signed [SAT_W-1:0] bias;
    logic signed [SAT_W-1:0] r;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    sat_round_t              res;
    bias = '0;
    if (shift != 0) begin
      bias = SAT_ONE <<< (shift - 1);
    end
    r  = (acc + bias) >>> shift;
    hi = (SAT_ONE <<< (out_w - 1)) - SAT_ONE;
    lo = ~hi;
    res.value = r;
    res.sat   = 1'b0;
    if (r > hi) begin
      res.value = hi;
      res.sat   = 1'b1;
    end else if (r < lo) begin
      res.value = lo;
      res.sat   = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/fir_fixed_mul_core.sv
// Pipelined A_W x B_W multiplier with valid/framing bits carried alongside the data.
// Latency: MUL_STAGES ce-enabled cycles (operand reg, product reg, MUL_STAGES-2 extra regs).
// Backpressure: none; ce freezes every register, one sample per ce-enabled cycle otherwise.
module fir_fixed_mul_core
  import fir_fixed_pkg::*;
#(
  parameter int A_W        = FIR_A_W,
  parameter int B_W        = FIR_B_W,
  parameter int B_SIGNED   = 0,
  parameter int MUL_STAGES = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   ce,
  input  logic                   in_valid,
  input  logic [A_W-1:0]         a,
  input  logic [B_W-1:0]         b,
  input  logic                   acc_first,
  input  logic                   acc_last,
  output logic                   p_valid,
  output logic [A_W+B_W-1:0]     p,
  output logic                   p_first,
  output logic                   p_last
);

  localparam int P_W = A_W + B_W;

  // b is widened by one bit so that both signednesses feed one signed multiply.
  logic signed [B_W:0]   b_ext;
  logic signed [A_W-1:0] a_q;
  logic signed [B_W:0]   b_q;
  logic signed [P_W-1:0] prod;

  // Index 0 is the product register, the rest are retiming stages.
  logic signed [P_W-1:0] p_pipe [MUL_STAGES-1];

  // Bit k tracks the sample sitting in pipeline stage k+1.
  logic [MUL_STAGES-1:0] vld_sr;
  logic [MUL_STAGES-1:0] first_sr;
  logic [MUL_STAGES-1:0] last_sr;

  assign b_ext = (B_SIGNED != 0) ? {b[B_W-1], b} : {1'b0, b};

  // The true product always fits in A_W+B_W signed bits, so computing it
  // modulo 2^P_W on sign-extended operands is exact.
  assign prod = P_W'(a_q) * P_W'(b_q);

  // Operand, product and retiming registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      a_q <= '0;
      b_q <= '0;
      for (int i = 0; i < MUL_STAGES-1; i++) begin
        p_pipe[i] <= '0;
      end
    end else if (ce) begin
      a_q       <= a;
      b_q       <= b_ext;
      p_pipe[0] <= prod;
      for (int i = 1; i < MUL_STAGES-1; i++) begin
        p_pipe[i] <= p_pipe[i-1];
      end
    end
  end

  // Valid and framing bits shift in lock-step with the data.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vld_sr   <= '0;
      first_sr <= '0;
      last_sr  <= '0;
    end else if (ce) begin
      vld_sr   <= {vld_sr[MUL_STAGES-2:0], in_valid};
      first_sr <= {first_sr[MUL_STAGES-2:0], acc_first};
      last_sr  <= {last_sr[MUL_STAGES-2:0], acc_last};
    end
  end

  assign p       = p_pipe[MUL_STAGES-2];
  assign p_valid = vld_sr[MUL_STAGES-1];
  assign p_first = first_sr[MUL_STAGES-1];
  assign p_last  = last_sr[MUL_STAGES-1];

endmodule

// File: rtl/fir_fixed_mac_pipe.sv
// Valid-tagged pipelined multiply-accumulate with framed sums and round/saturate output.
// Latency: MUL_STAGES+2 ce-enabled cycles from sample to out_valid.
// Backpressure: none; ce=0 holds every register (outputs included), reset overrides ce.
module fir_fixed_mac_pipe
  import fir_fixed_pkg::*;
#(
  parameter int A_W        = FIR_A_W,
  parameter int B_W        = FIR_B_W,
  parameter int B_SIGNED   = 0,
  parameter int MUL_STAGES = 4,
  parameter int ACC_W      = FIR_ACC_W,
  parameter int FRAC_SHIFT = FIR_FRAC_SHIFT,
  parameter int OUT_W      = FIR_OUT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ce,
  input  logic             in_valid,
  input  logic [A_W-1:0]   a,
  input  logic [B_W-1:0]   b,
  input  logic             acc_first,
  input  logic             acc_last,
  output logic             out_valid,
  output logic [OUT_W-1:0] dout,
  output logic             sat,
  output logic [ACC_W-1:0] p_full
);

  localparam int P_W = A_W + B_W;

  logic                  mul_vld;
  logic                  mul_first;
  logic                  mul_last;
  logic [P_W-1:0]        mul_p;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] acc_q;
  logic                  emit_q;
  sat_round_t            rnd;
  logic                  rnd_unused;

  fir_fixed_mul_core #(
    .A_W        (A_W),
    .B_W        (B_W),
    .B_SIGNED   (B_SIGNED),
    .MUL_STAGES (MUL_STAGES)
  ) u_mul (
    .clk       (clk),
    .reset_n   (reset_n),
    .ce        (ce),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .acc_first (acc_first),
    .acc_last  (acc_last),
    .p_valid   (mul_vld),
    .p         (mul_p),
    .p_first   (mul_first),
    .p_last    (mul_last)
  );

  assign prod_ext = ACC_W'($signed(mul_p));

  // Accumulate: a framed start reloads, anything else adds (wrapping);
  // invalid slots leave the running sum alone. emit_q marks a closed sum.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc_q  <= '0;
      emit_q <= 1'b0;
    end else if (ce) begin
      emit_q <= mul_vld & mul_last;
      if (mul_vld) begin
        acc_q <= mul_first ? prod_ext : (acc_q + prod_ext);
      end
    end
  end

  // Rounding and clipping run combinationally on the held accumulator.
  always_comb begin
    rnd = sat_round(SAT_W'(acc_q), FRAC_SHIFT, OUT_W);
  end

  // Only the low OUT_W bits of the clipped value carry information.
  assign rnd_unused = ^rnd.value[SAT_W-1:OUT_W];

  // Output register: pulse out_valid per closed sum, keep data between pulses.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      dout      <= '0;
      sat       <= 1'b0;
      p_full    <= '0;
    end else if (ce) begin
      out_valid <= emit_q;
      if (emit_q) begin
        p_full <= acc_q;
        dout   <= rnd.value[OUT_W-1:0];
        sat    <= rnd.sat;
      end
    end
  end

endmodule

// File: tb/tb_fir_fixed_mac_pipe.sv
// Self-checking bench for fir_fixed_mac_pipe: directed literal cases plus randomized traffic.
// Latency: expects results MUL_STAGES+2 ce-enabled cycles after each closing sample.
// Backpressure: exercises ce stalls and mid-stream resets against a scheduled reference model.
module tb_fir_fixed_mac_pipe;

  localparam int A_W        = 24;
  localparam int B_W        = 18;
  localparam int MUL_STAGES = 4;
  localparam int ACC_W      = 48;
  localparam int FRAC_SHIFT = 17;
  localparam int OUT_W      = 24;
  localparam int L          = MUL_STAGES + 2;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             ce;
  logic             in_valid;
  logic [A_W-1:0]   a;
  logic [B_W-1:0]   b;
  logic             acc_first;
  logic             acc_last;
  logic             out_valid;
  logic [OUT_W-1:0] dout;
  logic             sat;
  logic [ACC_W-1:0] p_full;
  logic             s_out_valid;
  logic [OUT_W-1:0] s_dout;
  logic             s_sat;
  logic [ACC_W-1:0] s_p_full;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  fir_fixed_mac_pipe dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ce        (ce),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .acc_first (acc_first),
    .acc_last  (acc_last),
    .out_valid (out_valid),
    .dout      (dout),
    .sat       (sat),
    .p_full    (p_full)
  );

  // Signed-coefficient variant sharing the same stimulus.
  fir_fixed_mac_pipe #(.B_SIGNED(1)) dut_s (
    .clk       (clk),
    .reset_n   (reset_n),
    .ce        (ce),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .acc_first (acc_first),
    .acc_last  (acc_last),
    .out_valid (s_out_valid),
    .dout      (s_dout),
    .sat       (s_sat),
    .p_full    (s_p_full)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                 name, act, act, exp, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    longint due;
    longint pf;
    longint dv;
    bit     st;
  } exp_t;

  exp_t             q[$];
  exp_t             e;
  longint           ce_cnt = 0;
  longint           m_acc  = 0;
  longint           prod;
  logic             e_vld  = 1'b0;
  logic             e_sat  = 1'b0;
  logic [OUT_W-1:0] e_dout = '0;
  logic [ACC_W-1:0] e_pf   = '0;

  function automatic longint wrap_acc(input longint x);
    logic [ACC_W-1:0] t;
    t = x[ACC_W-1:0];
    return longint'($signed(t));
  endfunction

  function automatic void round_sat(input longint acc, output longint v, output bit s);
    longint r;
    longint hi;
    longint lo;
    r = acc;
    if (FRAC_SHIFT > 0) r = r + (longint'(1) <<< (FRAC_SHIFT - 1));
    r  = r >>> FRAC_SHIFT;
    hi = (longint'(1) <<< (OUT_W - 1)) - 1;
    lo = -hi - 1;
    s  = 1'b0;
    v  = r;
    if (r > hi) begin v = hi; s = 1'b1; end
    else if (r < lo) begin v = lo; s = 1'b1; end
  endfunction

  // Sums are evaluated when their samples are accepted; each closed sum is
  // scheduled to appear L ce-enabled edges after its closing sample.
  always @(posedge clk) begin
    if (!reset_n) begin
      q.delete();
      m_acc  = 0;
      e_vld  = 1'b0;
      e_sat  = 1'b0;
      e_dout = '0;
      e_pf   = '0;
    end else if (ce) begin
      ce_cnt++;
      if (in_valid) begin
        prod  = longint'($signed(a)) * longint'(b);
        m_acc = acc_first ? wrap_acc(prod) : wrap_acc(m_acc + prod);
        if (acc_last) begin
          e.due = ce_cnt + L - 1;
          e.pf  = m_acc;
          round_sat(m_acc, e.dv, e.st);
          q.push_back(e);
        end
      end
      e_vld = 1'b0;
      if (q.size() > 0 && q[0].due == ce_cnt) begin
        e      = q.pop_front();
        e_vld  = 1'b1;
        e_pf   = ACC_W'(e.pf);
        e_dout = OUT_W'(e.dv);
        e_sat  = e.st;
      end
    end
  end

  // Every cycle, all outputs must match the model (covers hold and freeze).
  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_out_valid", longint'(out_valid), longint'(e_vld));
      chk("model_dout",      longint'(dout),      longint'(e_dout));
      chk("model_sat",       longint'(sat),       longint'(e_sat));
      chk("model_p_full",    longint'(p_full),    longint'(e_pf));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid  = 1'b0;
    acc_first = 1'b0;
    acc_last  = 1'b0;
    a         = A_W'($urandom);
    b         = B_W'($urandom);
  endtask

  task automatic drive(input logic [A_W-1:0] av, input logic [B_W-1:0] bv,
                       input logic f, input logic l);
    in_valid  = 1'b1;
    a         = av;
    b         = bv;
    acc_first = f;
    acc_last  = l;
    tick();
    idle_inputs();
  endtask

  task automatic wait_pulse(input int t0, input int max_cyc, output int lat, output bit got);
    got = 1'b0;
    lat = -1;
    for (int i = 0; i < max_cyc && !got; i++) begin
      if (out_valid) begin
        got = 1'b1;
        lat = cyc - t0;
      end else begin
        tick();
      end
    end
  endtask

  int t0;
  int lat;
  bit got;
  int pulses;
  int last_lat;
  longint last_dout;
  int st_lat[$];
  longint st_val[$];

  initial begin
    reset_n = 1'b0;
    ce      = 1'b1;
    idle_inputs();
    repeat (3) tick();
    reset_n = 1'b1;
    chk_en  = 1'b1;
    chk("reset_out_valid", longint'(out_valid), 0);
    chk("reset_dout",      longint'(dout), 0);
    chk("reset_p_full",    longint'(p_full), 0);
    chk("reset_sat",       longint'(sat), 0);
    repeat (2) tick();

    // Plain multiply
    t0 = cyc;
    drive(24'd256, 18'h20000, 1'b1, 1'b1);
    wait_pulse(t0, 20, lat, got);
    chk("mul_seen", longint'(got), 1);
    chk("mul_latency", lat, 6);
    chk("mul_dout", longint'(dout), 256);
    chk("mul_p_full", longint'(p_full), 33554432);
    chk("mul_sat", longint'(sat), 0);
    repeat (8) tick();

    // Unsigned vs signed coefficient, rounding toward +inf at half
    t0 = cyc;
    drive(24'hFFFFFF, 18'h3FFFF, 1'b1, 1'b1);
    wait_pulse(t0, 20, lat, got);
    chk("uns_seen", longint'(got), 1);
    chk("uns_p_full", longint'($signed(p_full)), -262143);
    chk("uns_dout", longint'(dout), 64'hFFFFFE);
    chk("sgn_out_valid", longint'(s_out_valid), 1);
    chk("sgn_p_full", longint'($signed(s_p_full)), 1);
    chk("sgn_dout", longint'(s_dout), 0);
    repeat (8) tick();

    // Four-sample accumulate
    t0 = cyc;
    for (int i = 0; i < 4; i++) drive(24'd1000, 18'h20000, i == 0, i == 3);
    pulses = 0;
    last_lat = -1;
    last_dout = -1;
    while (cyc - t0 <= 13) begin
      if (out_valid) begin
        pulses++;
        last_lat  = cyc - t0;
        last_dout = longint'(dout);
      end
      tick();
    end
    chk("acc_pulses", pulses, 1);
    chk("acc_latency", last_lat, 9);
    chk("acc_dout", last_dout, 4000);

    // Saturation both ways
    t0 = cyc;
    drive(24'h7FFFFF, 18'h3FFFF, 1'b1, 1'b1);
    wait_pulse(t0, 20, lat, got);
    chk("satp_seen", longint'(got), 1);
    chk("satp_dout", longint'(dout), 64'h7FFFFF);
    chk("satp_sat", longint'(sat), 1);
    repeat (8) tick();
    t0 = cyc;
    drive(24'h800000, 18'h3FFFF, 1'b1, 1'b1);
    wait_pulse(t0, 20, lat, got);
    chk("satn_seen", longint'(got), 1);
    chk("satn_dout", longint'(dout), 64'h800000);
    chk("satn_sat", longint'(sat), 1);
    repeat (8) tick();

    // Stall with ce low for two cycles after the second sample
    t0 = cyc;
    drive(24'd1, 18'h20000, 1'b1, 1'b1);
    drive(24'd2, 18'h20000, 1'b1, 1'b1);
    ce = 1'b0;
    repeat (2) tick();
    ce = 1'b1;
    drive(24'd3, 18'h20000, 1'b1, 1'b1);
    while (cyc - t0 <= 15) begin
      if (out_valid) begin
        st_lat.push_back(cyc - t0);
        st_val.push_back(longint'(dout));
      end
      tick();
    end
    chk("stall_count", st_val.size(), 3);
    if (st_val.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        chk("stall_value", st_val[i], i + 1);
        chk("stall_latency", st_lat[i], 8 + i);
      end
    end

    // Reset in the middle of a sum
    t0 = cyc;
    drive(24'd500, 18'h20000, 1'b1, 1'b0);
    reset_n = 1'b0;
    ce      = 1'b0;
    tick();
    reset_n = 1'b1;
    ce      = 1'b1;
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_p_full", longint'(p_full), 0);
    drive(24'd7, 18'h20000, 1'b0, 1'b1);
    pulses = 0;
    last_dout = -1;
    last_lat = -1;
    while (cyc - t0 <= 13) begin
      if (out_valid) begin
        pulses++;
        last_lat  = cyc - t0;
        last_dout = longint'(dout);
      end
      tick();
    end
    chk("rst_pulses", pulses, 1);
    chk("rst_dout", last_dout, 7);
    chk("rst_latency", last_lat, 8);

    // Randomized traffic with stalls and occasional resets
    for (int n = 0; n < 600; n++) begin
      ce        = ($urandom_range(9) != 0);
      reset_n   = ($urandom_range(149) != 0);
      in_valid  = $urandom_range(1) == 1;
      acc_first = ($urandom_range(3) == 0);
      acc_last  = ($urandom_range(2) == 0);
      if ($urandom_range(1) == 1) begin
        a = A_W'($urandom);
        b = B_W'($urandom);
      end else begin
        a = A_W'($urandom_range(4000)) - A_W'(2000);
        b = B_W'($urandom_range(300000));
      end
      tick();
    end
    reset_n = 1'b1;
    ce      = 1'b1;
    idle_inputs();
    repeat (12) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

endmodule
